// File: rtl/psum_mem_pkg.sv
// Shared definitions for the partial-sum memory controller: clear FSM states,
// status bit positions and the fixed read latency.
package psum_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    localparam int STAT_CLEAR_DONE = 0;
    localparam int STAT_ERR_WR_CLR = 1;
    localparam int STAT_ERR_OOB_WR = 2;
    localparam int STAT_ERR_OOB_RD = 3;

    localparam int RD_LATENCY = 2;

endpackage

// File: rtl/psum_sdp_bram.sv
// Inferred simple dual-port RAM: one write port, one registered read port.
// Collisions return old data; write-first behaviour is added by the caller.
module psum_sdp_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [2**DEPTH_LOG2];

    // Memory array write port and registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/psum_mem_ctrl.sv
// Partial-sum memory responder: accelerator read/write port, host readback port
// with lower read priority, and a zero-fill clear engine.
module psum_mem_ctrl
    import psum_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memctrl_wadd,
    input  logic                  memctrl_wren,
    input  logic [DATA_WIDTH-1:0] memctrl_idat,
    input  logic [ADDR_WIDTH-1:0] memctrl_radd,
    input  logic                  memctrl_rden,
    output logic [DATA_WIDTH-1:0] memctrl_odat,
    output logic                  memctrl_oval,
    input  logic [ADDR_WIDTH-1:0] host_radd,
    input  logic                  host_rden,
    output logic                  host_rrdy,
    output logic [DATA_WIDTH-1:0] host_rdat,
    output logic                  host_rval,
    input  logic                  i_clear,
    output logic                  o_clear_busy,
    output logic [3:0]            o_status
);

    localparam logic [DEPTH_LOG2:0] CLR_LAST = {1'b0, {DEPTH_LOG2{1'b1}}};
    localparam logic [DEPTH_LOG2:0] CLR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    function automatic logic is_oob(input logic [ADDR_WIDTH-1:0] addr);
        return |addr[ADDR_WIDTH-1:DEPTH_LOG2];
    endfunction

    clr_state_e            state_r, state_next_s;
    logic [DEPTH_LOG2:0]   clr_addr_r, clr_addr_next_s;
    logic                  clear_accept_s, clear_busy_r;
    logic                  wr_oob_s, wr_en_s;
    logic [DEPTH_LOG2-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  rd_host_s, rd_req_s, rd_oob_s, rd_fwd_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [DATA_WIDTH-1:0] bram_rdata_s, s1_data_s;
    logic                  s1_val_r, s1_host_r, s1_oob_r, s1_fwd_r;
    logic [DATA_WIDTH-1:0] s1_fwd_data_r;
    logic [3:0]            status_r, status_set_s;
    logic [DATA_WIDTH-1:0] memctrl_odat_r, host_rdat_r;
    logic                  memctrl_oval_r, host_rval_r;

    // Clear FSM next-state and sweep address
    always_comb begin
        state_next_s    = state_r;
        clr_addr_next_s = clr_addr_r;
        clear_accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_clear) begin
                    state_next_s    = ST_CLEAR;
                    clr_addr_next_s = {(DEPTH_LOG2+1){1'b0}};
                    clear_accept_s  = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_addr_next_s = clr_addr_r + CLR_ONE;
                if (clr_addr_r == CLR_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: begin
                state_next_s    = ST_IDLE;
                clr_addr_next_s = {(DEPTH_LOG2+1){1'b0}};
            end
        endcase
    end

    // Write port mux: clear engine owns the write port while busy
    always_comb begin
        wr_oob_s = is_oob(memctrl_wadd);
        if (clear_busy_r) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_addr_r[DEPTH_LOG2-1:0];
            wr_data_s = {DATA_WIDTH{1'b0}};
        end else begin
            wr_en_s   = memctrl_wren & ~wr_oob_s;
            wr_addr_s = memctrl_wadd[DEPTH_LOG2-1:0];
            wr_data_s = memctrl_idat;
        end
    end

    // Read arbitration, write-first forwarding detect and error events
    always_comb begin
        rd_host_s = host_rden & ~memctrl_rden & ~clear_busy_r & ~rst;
        rd_req_s  = memctrl_rden | rd_host_s;
        if (memctrl_rden) begin
            rd_addr_s = memctrl_radd;
        end else begin
            rd_addr_s = host_radd;
        end
        rd_oob_s = is_oob(rd_addr_s);
        rd_fwd_s = wr_en_s & (wr_addr_s == rd_addr_s[DEPTH_LOG2-1:0]);
        status_set_s                  = 4'b0000;
        status_set_s[STAT_ERR_OOB_RD] = rd_req_s & rd_oob_s;
        status_set_s[STAT_ERR_OOB_WR] = memctrl_wren & wr_oob_s;
        status_set_s[STAT_ERR_WR_CLR] = memctrl_wren & clear_busy_r;
        status_set_s[STAT_CLEAR_DONE] = (state_r == ST_DONE);
    end

    psum_sdp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_req_s),
        .rd_addr (rd_addr_s[DEPTH_LOG2-1:0]),
        .rd_data (bram_rdata_s)
    );

    // Stage-1 data select: OOB forces zero, forwarded write beats the array
    always_comb begin
        if (s1_oob_r) begin
            s1_data_s = {DATA_WIDTH{1'b0}};
        end else if (s1_fwd_r) begin
            s1_data_s = s1_fwd_data_r;
        end else begin
            s1_data_s = bram_rdata_s;
        end
    end

    // FSM state, sticky status, tag pipe and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            clr_addr_r     <= {(DEPTH_LOG2+1){1'b0}};
            clear_busy_r   <= 1'b0;
            status_r       <= 4'b0000;
            s1_val_r       <= 1'b0;
            s1_host_r      <= 1'b0;
            s1_oob_r       <= 1'b0;
            s1_fwd_r       <= 1'b0;
            s1_fwd_data_r  <= {DATA_WIDTH{1'b0}};
            memctrl_oval_r <= 1'b0;
            memctrl_odat_r <= {DATA_WIDTH{1'b0}};
            host_rval_r    <= 1'b0;
            host_rdat_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r        <= state_next_s;
            clr_addr_r     <= clr_addr_next_s;
            clear_busy_r   <= (state_next_s == ST_CLEAR);
            status_r       <= (clear_accept_s ? 4'b0000 : status_r) | status_set_s;
            s1_val_r       <= rd_req_s;
            s1_host_r      <= rd_host_s;
            s1_oob_r       <= rd_oob_s;
            s1_fwd_r       <= rd_fwd_s;
            s1_fwd_data_r  <= wr_data_s;
            memctrl_oval_r <= s1_val_r & ~s1_host_r;
            host_rval_r    <= s1_val_r & s1_host_r;
            if (s1_val_r & ~s1_host_r) begin
                memctrl_odat_r <= s1_data_s;
            end
            if (s1_val_r & s1_host_r) begin
                host_rdat_r <= s1_data_s;
            end
        end
    end

    assign memctrl_odat = memctrl_odat_r;
    assign memctrl_oval = memctrl_oval_r;
    assign host_rdat    = host_rdat_r;
    assign host_rval    = host_rval_r;
    assign host_rrdy    = rd_host_s;
    assign o_clear_busy = clear_busy_r;
    assign o_status     = status_r;

endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Directed self-checking bench for psum_mem_ctrl: latency, forwarding,
// arbitration, OOB handling, clear engine and reset mid-clear.
module tb_psum_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] memctrl_wadd, memctrl_idat, memctrl_radd, memctrl_odat;
    logic        memctrl_wren, memctrl_rden, memctrl_oval;
    logic [31:0] host_radd, host_rdat;
    logic        host_rden, host_rrdy, host_rval;
    logic        i_clear, o_clear_busy;
    logic [3:0]  o_status;

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    always #5 clk = ~clk;

    psum_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .memctrl_wadd (memctrl_wadd),
        .memctrl_wren (memctrl_wren),
        .memctrl_idat (memctrl_idat),
        .memctrl_radd (memctrl_radd),
        .memctrl_rden (memctrl_rden),
        .memctrl_odat (memctrl_odat),
        .memctrl_oval (memctrl_oval),
        .host_radd    (host_radd),
        .host_rden    (host_rden),
        .host_rrdy    (host_rrdy),
        .host_rdat    (host_rdat),
        .host_rval    (host_rval),
        .i_clear      (i_clear),
        .o_clear_busy (o_clear_busy),
        .o_status     (o_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_write(input logic [31:0] addr, input logic [31:0] data);
        memctrl_wren = 1'b1;
        memctrl_wadd = addr;
        memctrl_idat = data;
        tick();
        memctrl_wren = 1'b0;
    endtask

    task automatic acc_read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        memctrl_rden = 1'b1;
        memctrl_radd = addr;
        tick();
        memctrl_rden = 1'b0;
        tick();
        check({tag, "_oval"}, {31'd0, memctrl_oval}, 32'd1);
        check({tag, "_odat"}, memctrl_odat, exp);
    endtask

    task automatic host_read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        host_rden = 1'b1;
        host_radd = addr;
        #1;
        check({tag, "_rrdy"}, {31'd0, host_rrdy}, 32'd1);
        @(posedge clk);
        #1;
        host_rden = 1'b0;
        tick();
        check({tag, "_rval"}, {31'd0, host_rval}, 32'd1);
        check({tag, "_rdat"}, host_rdat, exp);
    endtask

    initial begin
        rst = 1'b1;
        memctrl_wadd = 32'd0; memctrl_idat = 32'd0; memctrl_wren = 1'b0;
        memctrl_radd = 32'd0; memctrl_rden = 1'b0;
        host_radd = 32'd0; host_rden = 1'b0; i_clear = 1'b0;
        repeat (3) tick();
        check("rst_oval", {31'd0, memctrl_oval}, 32'd0);
        check("rst_odat", memctrl_odat, 32'd0);
        check("rst_hval", {31'd0, host_rval}, 32'd0);
        check("rst_hdat", host_rdat, 32'd0);
        check("rst_rrdy", {31'd0, host_rrdy}, 32'd0);
        check("rst_busy", {31'd0, o_clear_busy}, 32'd0);
        check("rst_status", {28'd0, o_status}, 32'd0);
        rst = 1'b0;
        tick();

        // write then read one cycle later, with latency probe
        acc_write(32'd5, 32'h0000_1234);
        memctrl_rden = 1'b1;
        memctrl_radd = 32'd5;
        tick();
        memctrl_rden = 1'b0;
        check("lat_n1_oval", {31'd0, memctrl_oval}, 32'd0);
        tick();
        check("wr_rd_oval", {31'd0, memctrl_oval}, 32'd1);
        check("wr_rd_odat", memctrl_odat, 32'h0000_1234);

        // same-cycle write and read: write-first forwarding
        memctrl_wren = 1'b1; memctrl_wadd = 32'd9; memctrl_idat = 32'h0000_00AA;
        memctrl_rden = 1'b1; memctrl_radd = 32'd9;
        tick();
        memctrl_wren = 1'b0; memctrl_rden = 1'b0;
        tick();
        check("fwd_oval", {31'd0, memctrl_oval}, 32'd1);
        check("fwd_odat", memctrl_odat, 32'h0000_00AA);

        // host stalled behind four accelerator reads
        acc_write(32'd3, 32'h0000_3333);
        for (int i = 0; i < 4; i++) acc_write(32'(10 + i), 32'(32'hA0 + i));
        host_radd = 32'd3;
        for (int c = 0; c < 8; c++) begin
            memctrl_rden = (c < 4);
            memctrl_radd = 32'(10 + c);
            host_rden    = (c <= 4);
            #1;
            check("arb_rrdy", {31'd0, host_rrdy}, {31'd0, c == 4});
            @(posedge clk);
            #1;
            if (c >= 1 && c <= 4) begin
                check("arb_oval", {31'd0, memctrl_oval}, 32'd1);
                check("arb_odat", memctrl_odat, 32'(32'hA0 + c - 1));
            end else begin
                check("arb_oval_idle", {31'd0, memctrl_oval}, 32'd0);
            end
            check("arb_hval", {31'd0, host_rval}, {31'd0, c == 5});
            if (c == 5) check("arb_hdat", host_rdat, 32'h0000_3333);
        end
        memctrl_rden = 1'b0;
        host_rden = 1'b0;

        // out-of-bounds write and read
        acc_write(32'd0, 32'h0000_0077);
        acc_write(32'h0001_0000, 32'h0000_0055);
        check("oob_wr_err", {31'd0, o_status[2]}, 32'd1);
        acc_read_check("oob_mem0", 32'd0, 32'h0000_0077);
        acc_read_check("oob_rd", 32'h0001_0000, 32'd0);
        check("oob_rd_err", {31'd0, o_status[3]}, 32'd1);

        // full fill then clear sweep
        for (int i = 0; i < 4096; i++) begin
            memctrl_wren = 1'b1; memctrl_wadd = 32'(i); memctrl_idat = 32'hFFFF_FFFF;
            tick();
        end
        memctrl_wren = 1'b0;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_status_cleared", {28'd0, o_status}, 32'd0);
        cnt = 0;
        while (o_clear_busy && cnt < 5000) begin
            memctrl_wren = (cnt == 10);
            memctrl_wadd = 32'd5;
            memctrl_idat = 32'd1;
            tick();
            cnt++;
        end
        memctrl_wren = 1'b0;
        check("clr_busy_cycles", 32'(cnt), 32'd4096);
        tick();
        check("clr_status_done", {28'd0, o_status}, 32'h0000_0003);
        host_read_check("clr_h0", 32'd0, 32'd0);
        host_read_check("clr_h4095", 32'd4095, 32'd0);
        host_read_check("clr_h5_dropped", 32'd5, 32'd0);

        // reset in the middle of a clear
        for (int i = 0; i < 256; i++) acc_write(32'(i), 32'hFFFF_FFFF);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        repeat (100) tick();
        check("abort_busy_pre", {31'd0, o_clear_busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("abort_busy", {31'd0, o_clear_busy}, 32'd0);
        check("abort_status", {28'd0, o_status}, 32'd0);
        rst = 1'b0;
        tick();
        acc_read_check("abort_a200", 32'd200, 32'hFFFF_FFFF);
        acc_read_check("abort_a50", 32'd50, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_mem_ctrl.md
Name: psum_mem_ctrl

Overview:
- On-chip partial-sum memory responder: the other end of the memctrl0 read/write request interface driven by the psum accumulation controller.
- Serves accumulator writes and read-for-accumulate requests from a simple dual-port BRAM (one write port, one read port), with fixed read latency and same-cycle write-first forwarding.
- Adds a host readback port for draining results and a clear engine that zero-fills the memory between layers.

Parameters:
- ADDR_WIDTH, 32, request address width (word addresses).
- DATA_WIDTH, 32, word width.
- DEPTH_LOG2, 12, log2 of the number of words (4096); only addr[DEPTH_LOG2-1:0] indexes the array.
- RD_LATENCY, 2, cycles from an accepted read to its valid output; fixed at 2 (BRAM register + output register).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- memctrl_wadd  in  ADDR_WIDTH  accumulator write address.
- memctrl_wren  in  1  accumulator write strobe.
- memctrl_idat  in  DATA_WIDTH  accumulator write data.
- memctrl_radd  in  ADDR_WIDTH  accumulator read address.
- memctrl_rden  in  1  accumulator read strobe.
- memctrl_odat  out  DATA_WIDTH  accumulator read data.
- memctrl_oval  out  1  accumulator read data valid.
- host_radd  in  ADDR_WIDTH  host readback address.
- host_rden  in  1  host read request (held until host_rrdy).
- host_rrdy  out  1  host request accepted this cycle.
- host_rdat  out  DATA_WIDTH  host read data.
- host_rval  out  1  host read data valid.
- i_clear  in  1  start zero-fill (single-cycle pulse).
- o_clear_busy  out  1  clear in progress.
- o_status  out  4  {err_oob_rd, err_oob_wr, err_wr_during_clear, clear_done}; sticky bits.

Behaviour:
- Reset: all outputs 0. Memory contents are not reset. FSM goes to IDLE; read pipeline valids are cleared.
- Address check: any address with nonzero bits above DEPTH_LOG2-1 is out of bounds (OOB).
  - OOB write: dropped; sets err_oob_wr.
  - OOB read: still returns a response with data 0 and valid at normal latency; sets err_oob_rd.
- Write: accepted the same cycle; mem[wadd] <= idat.
- Read port arbitration, per cycle: clear engine does not use the read port. Accelerator read has priority over host read. host_rrdy = host_rden & ~memctrl_rden & ~o_clear_busy.
- Read latency: a request in cycle N gives data and valid in cycle N+2 (memctrl_oval, or host_rval). Both streams are fully pipelined, one request per cycle, with in-order responses. A 1-bit owner tag travels down the 2-stage pipe.
- Forwarding: a same-cycle write and read to the same in-range address return the new write data (write-first). A write in N and a read in N+1 return the new data naturally.
- Clear FSM:
  - IDLE -> CLEAR on i_clear. Loads clr_addr = 0 and clears clear_done.
  - CLEAR: writes 0 to mem[clr_addr] each cycle and increments clr_addr. Exits after address 2^DEPTH_LOG2-1.
  - CLEAR -> DONE, then DONE -> IDLE next cycle, setting clear_done.
  - o_clear_busy is high in CLEAR only.
  - During CLEAR, accelerator writes are dropped and set err_wr_during_clear. Accelerator reads are still served, returning current memory or 0 if already cleared. Host reads stall.
  - i_clear in CLEAR or DONE is ignored.
- Sticky errors clear only on rst or on i_clear accepted in IDLE.
- rst mid-clear: aborts to IDLE; the memory is partially cleared and clear_done = 0.
- Wrap: clr_addr is DEPTH_LOG2+1 bits wide, so the terminal compare does not wrap.

Decomposition:
- Shared package psum_mem_pkg holds:
  - FSM state encoding (IDLE, CLEAR, DONE).
  - o_status bit index constants.
  - RD_LATENCY constant.
- One sub-module, psum_sdp_bram: inferred simple dual-port RAM with registered read, parameterised by DATA_WIDTH and DEPTH_LOG2.
- Forwarding, arbitration, the tag pipe and the FSM live in psum_mem_ctrl.

Test Plan:
- Write 0x1234 at addr 5 in cycle 0; read addr 5 in cycle 1 -> memctrl_oval=1 in cycle 3 with memctrl_odat=0x1234.
- Same-cycle wren and rden, both to addr 9, data 0xAA -> memctrl_odat=0xAA two cycles later.
- host_rden held on addr 3 while memctrl_rden is active for 4 consecutive cycles:
  - host_rrdy stays 0 during those cycles and goes 1 in the first free cycle.
  - host_rval follows 2 cycles later with mem[3].
  - All 4 accelerator responses arrive in order.
- OOB write at addr 0x0001_0000 with data 0x55 -> mem[0] is unchanged and err_oob_wr=1. OOB read -> odat=0 with oval, and err_oob_rd=1.
- Fill all words with 0xFFFFFFFF, pulse i_clear:
  - o_clear_busy is high for exactly 4096 cycles and clear_done sets.
  - Host reads of addr 0 and addr 4095 return 0.
  - An accelerator write issued mid-clear sets err_wr_during_clear.
- Assert rst at clear cycle 100 -> o_clear_busy=0 the next cycle, o_status=0, and addr 200 still reads 0xFFFFFFFF.
